// File: rtl/rom_loadable_sync.sv
// ---------------------------------------------------------------------------
// rom_loadable_sync
//
// Purpose:
//   Synchronous program ROM for the arcade core. Its contents are downloaded
//   at boot (or on reload) as a byte stream. The block assembles the bytes
//   into DATA_W-bit words and writes them into an inferred block RAM. It then
//   serves CPU reads with a fixed READ_LAT (1 or 2) latency and a valid strobe.
//
// Parameters:
//   DATA_W     word width, multiple of 8 in the range 8..64
//   ADDR_W     word address width, depth = 2**ADDR_W
//   READ_LAT   read latency in clocks; 2 adds an output register
//   BIG_ENDIAN 1: first byte of a word lands in the MSBs, 0: in the LSBs
//
// Optional feature (macro ROM_CHECKSUM_EN):
//   Adds output csum[15:0], the mod-2^16 sum of every accepted download byte.
//   It is cleared on reset and on dl_start and is frozen once the load
//   completes. Without the macro, both the port and its adder are absent.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   dl_start            pulse: begin a (re)load at word 0 (highest priority)
//   dl_valid, dl_data   download byte strobe and data
//   dl_end              pulse: terminate the load early (partial word padded)
//   dl_ready            a byte is accepted this cycle (high while loading)
//   dl_done             one-cycle pulse when a load completes
//   overrun             sticky: a byte arrived after a full load
//   loaded              contents valid, block is in RUN
//   a, ce, oe           read address and read qualifiers (ce && oe = read)
//   d, d_valid          read data; d_valid is high for one cycle per read.
//                       d is 0 for reads issued outside RUN.
// ---------------------------------------------------------------------------
module rom_loadable_sync #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 13,
  parameter int READ_LAT   = 1,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dl_start,
  input  logic              dl_valid,
  input  logic [7:0]        dl_data,
  input  logic              dl_end,
  output logic              dl_ready,
  output logic              dl_done,
  output logic              overrun,
  output logic              loaded,
  input  logic [ADDR_W-1:0] a,
  input  logic              ce,
  input  logic              oe,
  output logic [DATA_W-1:0] d,
  output logic              d_valid
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [15:0]       csum
`endif
);

  localparam int                NBYTES    = DATA_W / 8;
  localparam int                CNT_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOAD,
    S_RUN
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_byte_cnt;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_asm;
  logic              r_full;      // last load filled the whole ROM
  logic              r_overrun;
  logic              r_dl_ready;
  logic              r_dl_done;
  logic              r_loaded;

  logic              w_accept;
  logic              w_end;
  logic              w_last_byte;
  logic              w_full_wr;
  logic              w_part_wr;
  logic              w_ram_we;
  logic              w_full_done;
  logic              w_finish;
  logic [DATA_W-1:0] w_asm_merged;
  logic [DATA_W-1:0] w_wdata;

  // -------------------------------------------------------------------------
  // Download datapath: merge the incoming byte and decide RAM writes
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_asm_merged = r_asm;
    for (int i = 0; i < NBYTES; i++) begin
      if (r_byte_cnt == CNT_W'(i)) begin
        if (BIG_ENDIAN) w_asm_merged[(NBYTES-1-i)*8 +: 8] = dl_data;
        else            w_asm_merged[i*8 +: 8]            = dl_data;
      end
    end

    // dl_start outranks both the byte and the end pulse in the same cycle.
    w_accept    = (r_state == S_LOAD) && r_dl_ready && dl_valid && !dl_start;
    w_end       = (r_state == S_LOAD) && dl_end && !dl_start;
    w_last_byte = (r_byte_cnt == LAST_BYTE);
    w_full_wr   = w_accept && w_last_byte;
    // An early end flushes a partial word. Partial means the word still holds
    // bytes after this cycle's byte (if any) is merged. The assembly register
    // is zero in every unfilled lane, which gives the 0x00 padding.
    w_part_wr   = w_end && (w_accept ? !w_last_byte : (r_byte_cnt != '0));
    w_ram_we    = w_full_wr || w_part_wr;
    w_wdata     = w_accept ? w_asm_merged : r_asm;
    w_full_done = w_full_wr && (r_waddr == LAST_ADDR);
    w_finish    = w_full_done || w_end;
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered status outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_EMPTY;
      r_byte_cnt <= '0;
      r_waddr    <= '0;
      r_asm      <= '0;
      r_full     <= 1'b0;
      r_overrun  <= 1'b0;
      r_dl_ready <= 1'b0;
      r_dl_done  <= 1'b0;
      r_loaded   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // right-hand side in this block sees the pre-edge values.
      r_dl_done <= 1'b0;
      if (dl_start) begin
        r_state    <= S_LOAD;
        r_byte_cnt <= '0;
        r_waddr    <= '0;
        r_asm      <= '0;
        r_full     <= 1'b0;
        r_overrun  <= 1'b0;
        r_dl_ready <= 1'b1;
        r_loaded   <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            if (w_accept) begin
              if (w_last_byte) begin
                r_byte_cnt <= '0;
                r_asm      <= '0;
                r_waddr    <= r_waddr + 1'b1;
              end else begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
                r_asm      <= w_asm_merged;
              end
            end
            // The completion overrides the byte bookkeeping above.
            if (w_finish) begin
              r_state    <= S_RUN;
              r_byte_cnt <= '0;
              r_asm      <= '0;
              r_full     <= w_full_done;
              r_dl_ready <= 1'b0;
              r_dl_done  <= 1'b1;
              r_loaded   <= 1'b1;
            end
          end
          S_RUN: begin
            if (r_full && dl_valid) r_overrun <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign dl_ready = r_dl_ready;
  assign dl_done  = r_dl_done;
  assign overrun  = r_overrun;
  assign loaded   = r_loaded;

  // -------------------------------------------------------------------------
  // Block RAM: one write port for the download, one registered read port
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_mem_q;
  logic              w_rd;

  assign w_rd = ce && oe;

  // NOTE: the array and its read register have no reset, so they map onto
  // block RAM. The bytes from the last load persist across a reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[r_waddr] <= w_wdata;
    if (w_rd)     r_mem_q        <= r_mem[a];
  end

  // Read qualifiers. They carry the reset, so d and d_valid clear
  // asynchronously even though r_mem_q does not.
  logic              r_rd_v;
  logic              r_rd_run;
  logic [DATA_W-1:0] w_d1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_v   <= 1'b0;
      r_rd_run <= 1'b0;
    end else begin
      r_rd_v <= w_rd;
      if (w_rd) r_rd_run <= (r_state == S_RUN);
    end
  end

  // Both terms update only on a read, so d holds between reads.
  assign w_d1 = r_rd_run ? r_mem_q : '0;

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] r_d2;
      logic              r_v2;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_d2 <= '0;
          r_v2 <= 1'b0;
        end else begin
          r_v2 <= r_rd_v;
          if (r_rd_v) r_d2 <= w_d1;
        end
      end

      assign d       = r_d2;
      assign d_valid = r_v2;
    end else begin : g_lat1
      assign d       = w_d1;
      assign d_valid = r_rd_v;
    end
  endgenerate

`ifdef ROM_CHECKSUM_EN
  // -------------------------------------------------------------------------
  // Download checksum. Bytes are accepted only in LOAD, so the sum stops
  // changing once dl_done fires. Padding never passes through here.
  // -------------------------------------------------------------------------
  logic [15:0] r_csum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_csum <= '0;
    else if (dl_start) r_csum <= '0;
    else if (w_accept) r_csum <= r_csum + 16'(dl_data);
  end

  assign csum = r_csum;
`endif

endmodule

// File: tb/tb_rom_loadable_sync.sv
// ---------------------------------------------------------------------------
// tb_rom_loadable_sync
//
// Two ROM instances share one stimulus bus, both with DATA_W=16, ADDR_W=4:
//   u_be : BIG_ENDIAN=1, READ_LAT=1
//   u_le : BIG_ENDIAN=0, READ_LAT=2
// A behavioural model tracks the load as a byte list per word, plus one
// memory image per byte order and per-latency read results. It is compared
// against both instances on every falling edge. Directed sequences pin the
// model with hand-computed literals; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_rom_loadable_sync;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dl_start, dl_valid, dl_end;
  logic [7:0]  dl_data;
  logic [3:0]  a;
  logic        ce, oe;

  logic        dl_ready_be, dl_done_be, overrun_be, loaded_be, d_valid_be;
  logic [15:0] d_be;
  logic        dl_ready_le, dl_done_le, overrun_le, loaded_le, d_valid_le;
  logic [15:0] d_le;
`ifdef ROM_CHECKSUM_EN
  logic [15:0] csum_be, csum_le;
`endif

  always #5 clk = ~clk;

  rom_loadable_sync #(.DATA_W(16), .ADDR_W(4), .READ_LAT(1), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .reset_n(reset_n), .dl_start(dl_start), .dl_valid(dl_valid),
    .dl_data(dl_data), .dl_end(dl_end), .dl_ready(dl_ready_be), .dl_done(dl_done_be),
    .overrun(overrun_be), .loaded(loaded_be), .a(a), .ce(ce), .oe(oe),
    .d(d_be), .d_valid(d_valid_be)
`ifdef ROM_CHECKSUM_EN
    , .csum(csum_be)
`endif
  );

  rom_loadable_sync #(.DATA_W(16), .ADDR_W(4), .READ_LAT(2), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .reset_n(reset_n), .dl_start(dl_start), .dl_valid(dl_valid),
    .dl_data(dl_data), .dl_end(dl_end), .dl_ready(dl_ready_le), .dl_done(dl_done_le),
    .overrun(overrun_le), .loaded(loaded_le), .a(a), .ce(ce), .oe(oe),
    .d(d_le), .d_valid(d_valid_le)
`ifdef ROM_CHECKSUM_EN
    , .csum(csum_le)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model
  // -------------------------------------------------------------------------
  typedef enum {M_EMPTY, M_LOAD, M_RUN} mstate_e;

  mstate_e     m_state;
  logic [7:0]  m_bytes[$];      // bytes of the word being assembled, in arrival order
  int          m_waddr;
  bit          m_full, m_overrun, m_done;
  logic [15:0] m_csum;
  logic [15:0] m_mem_be[16];
  logic [15:0] m_mem_le[16];
  bit          m_dv1, m_dv2, m_pend_v;
  logic [15:0] m_d1, m_d2, m_pend_d;

  // Packs a word from its byte list; lanes with no byte are 0x00.
  function automatic logic [15:0] pack(input logic [7:0] q[$], input bit be);
    logic [7:0] b0, b1;
    b0 = (q.size() > 0) ? q[0] : 8'h00;
    b1 = (q.size() > 1) ? q[1] : 8'h00;
    return be ? {b0, b1} : {b1, b0};
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    bit          rd;
    logic [15:0] rv_be, rv_le;
    if (!reset_n) begin
      m_state   = M_EMPTY;
      m_bytes.delete();
      m_waddr   = 0;
      m_full    = 1'b0;
      m_overrun = 1'b0;
      m_done    = 1'b0;
      m_csum    = '0;
      m_dv1     = 1'b0; m_d1 = '0;
      m_dv2     = 1'b0; m_d2 = '0;
      m_pend_v  = 1'b0; m_pend_d = '0;
    end else begin
      // Reads see the state and contents from before this edge.
      rd    = ce && oe;
      rv_be = (m_state == M_RUN) ? m_mem_be[a] : 16'h0000;
      rv_le = (m_state == M_RUN) ? m_mem_le[a] : 16'h0000;
      m_dv2 = m_pend_v;
      if (m_pend_v) m_d2 = m_pend_d;
      m_pend_v = rd;
      if (rd) m_pend_d = rv_le;
      m_dv1 = rd;
      if (rd) m_d1 = rv_be;

      m_done = 1'b0;
      if (dl_start) begin
        m_state   = M_LOAD;
        m_bytes.delete();
        m_waddr   = 0;
        m_full    = 1'b0;
        m_overrun = 1'b0;
        m_csum    = '0;
      end else if (m_state == M_LOAD) begin
        if (dl_valid) begin
          m_bytes.push_back(dl_data);
          m_csum = m_csum + 16'(dl_data);
          if (m_bytes.size() == 2) begin
            m_mem_be[m_waddr] = pack(m_bytes, 1'b1);
            m_mem_le[m_waddr] = pack(m_bytes, 1'b0);
            m_bytes.delete();
            if (m_waddr == 15) begin
              m_state = M_RUN;
              m_full  = 1'b1;
              m_done  = 1'b1;
            end else begin
              m_waddr++;
            end
          end
        end
        if (dl_end && m_state == M_LOAD) begin
          if (m_bytes.size() != 0) begin
            m_mem_be[m_waddr] = pack(m_bytes, 1'b1);
            m_mem_le[m_waddr] = pack(m_bytes, 1'b0);
          end
          m_bytes.delete();
          m_state = M_RUN;
          m_done  = 1'b1;
        end
      end else if (m_state == M_RUN && m_full && dl_valid) begin
        m_overrun = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-cycle comparison against the model
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("be_loaded",  loaded_be,   m_state == M_RUN);
      check("be_ready",   dl_ready_be, m_state == M_LOAD);
      check("be_done",    dl_done_be,  m_done);
      check("be_overrun", overrun_be,  m_overrun);
      check("be_dvalid",  d_valid_be,  m_dv1);
      check("be_d",       d_be,        m_d1);
      check("le_loaded",  loaded_le,   m_state == M_RUN);
      check("le_ready",   dl_ready_le, m_state == M_LOAD);
      check("le_done",    dl_done_le,  m_done);
      check("le_overrun", overrun_le,  m_overrun);
      check("le_dvalid",  d_valid_le,  m_dv2);
      check("le_d",       d_le,        m_d2);
`ifdef ROM_CHECKSUM_EN
      check("be_csum",    csum_be,     m_csum);
      check("le_csum",    csum_le,     m_csum);
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  // Consumes the current inputs at the next rising edge, then clears the pulses.
  task automatic step();
    @(posedge clk);
    #1;
    dl_start = 1'b0;
    dl_valid = 1'b0;
    dl_end   = 1'b0;
    ce       = 1'b0;
    oe       = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    dl_valid = 1'b1;
    dl_data  = b;
    step();
  endtask

  task automatic rd(input logic [3:0] addr);
    a  = addr;
    ce = 1'b1;
    oe = 1'b1;
    step();
  endtask

  initial begin
    reset_n  = 1'b0;
    dl_start = 1'b0; dl_valid = 1'b0; dl_end = 1'b0; dl_data = '0;
    a = '0; ce = 1'b0; oe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_loaded", loaded_be, 1'b0);
    check("rst_ready",  dl_ready_be, 1'b0);
    check("rst_dvalid", d_valid_be, 1'b0);
    check("rst_d",      d_le, 16'h0000);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Full big-endian load of 0x00..0x1F.
    dl_start = 1'b1;
    step();
    check("start_ready", dl_ready_be, 1'b1);
    for (int i = 0; i < 32; i++) begin
      send(8'(i));
      if (i == 30) check("done_early", dl_done_be, 1'b0);
    end
    check("full_done",   dl_done_be, 1'b1);
    check("full_loaded", loaded_be, 1'b1);
    check("full_ready",  dl_ready_be, 1'b0);
`ifdef ROM_CHECKSUM_EN
    check("csum_full", csum_be, 16'h01F0);
`endif
    step();
    check("done_pulse_width", dl_done_be, 1'b0);
    rd(4'd3);
    check("rd3_valid", d_valid_be, 1'b1);
    check("rd3_data",  d_be, 16'h0607);
    check("rd3_le_lat", d_valid_le, 1'b0);
    step();
    check("rd3_le_data", d_le, 16'h0706);

    // Back-to-back latency-2 reads of words 0..3.
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        a = 4'(k); ce = 1'b1; oe = 1'b1;
      end
      step();
      if (k >= 1 && k <= 4) begin
        check("lat2_valid", d_valid_le, 1'b1);
        check("lat2_data",  d_le, 16'(((2*(k-1)+1) << 8) | (2*(k-1))));
      end else begin
        check("lat2_idle", d_valid_le, 1'b0);
      end
    end

    // A byte after a full load sets a sticky overrun and leaves the ROM alone.
    send(8'hEE);
    check("overrun_set", overrun_be, 1'b1);
    step();
    check("overrun_sticky", overrun_be, 1'b1);
    rd(4'd15);
    check("overrun_ram", d_be, 16'h1E1F);
    dl_start = 1'b1;
    step();
    check("restart_overrun", overrun_be, 1'b0);
    check("restart_loaded",  loaded_be, 1'b0);
`ifdef ROM_CHECKSUM_EN
    check("csum_restart", csum_be, 16'h0000);
`endif

    // Early end after three bytes.
    send(8'hAA);
    send(8'h55);
    send(8'h11);
    dl_end = 1'b1;
    step();
    check("end_done",   dl_done_le, 1'b1);
    check("end_loaded", loaded_le, 1'b1);
    rd(4'd0);
    check("end_be_w0", d_be, 16'hAA55);
    rd(4'd1);
    check("end_be_w1", d_be, 16'h1100);
    check("end_le_w0", d_le, 16'h55AA);
    rd(4'd2);
    check("end_le_w1", d_le, 16'h0011);
    check("end_be_keep", d_be, 16'h0405);

    // Reset in the middle of a load.
    dl_start = 1'b1;
    step();
    for (int i = 0; i < 10; i++) send(8'($urandom));
    check("pre_rst_ready", dl_ready_be, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_loaded", loaded_be, 1'b0);
    check("arst_ready",  dl_ready_le, 1'b0);
    check("arst_d_be",   d_be, 16'h0000);
    check("arst_d_le",   d_le, 16'h0000);
    #1 reset_n = 1'b1;
    rd(4'd5);
    check("empty_rd_valid", d_valid_be, 1'b1);
    check("empty_rd_data",  d_be, 16'h0000);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      dl_start = (n == 0) || ($urandom_range(0, 79) == 0);
      dl_valid = ($urandom_range(0, 3) != 0);
      dl_data  = 8'($urandom);
      dl_end   = ($urandom_range(0, 59) == 0);
      ce       = 1'($urandom_range(0, 1));
      oe       = ($urandom_range(0, 3) != 0);
      a        = 4'($urandom);
      step();
    end
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rom_loadable_sync.md
Name: rom_loadable_sync

Overview:
- Parametrised synchronous program ROM for the arcade core; successor to the fixed 8K x 16 case-table ROMs.
- Contents are not baked in at synthesis. They are downloaded as a byte stream at boot, or on reload, from the platform loader.
- Bytes are assembled into DATA_W-bit words and written to inferred block RAM.
- Serves CPU-side reads with a fixed, parametrised latency and a valid strobe.

Parameters:
- DATA_W, 16: word width in bits. Must be a multiple of 8, range 8..64.
- ADDR_W, 13: word address width. Depth is 2^ADDR_W words.
- READ_LAT, 1: read latency in clocks, 1 or 2. A value of 2 adds an output register.
- BIG_ENDIAN, 1: 1 means the first byte of each word lands in the MSBs; 0 means it lands in the LSBs.

Ports:
- clk, in, 1: single clock.
- reset_n, in, 1: asynchronous, active-low reset.
- dl_start, in, 1: one-cycle pulse that begins a (re)load at word 0.
- dl_valid, in, 1: dl_data is valid this cycle.
- dl_data, in, 8: download byte.
- dl_end, in, 1: one-cycle pulse that terminates the load early.
- dl_ready, out, 1: block accepts a byte this cycle.
- dl_done, out, 1: one-cycle pulse when a load completes.
- overrun, out, 1: sticky flag; a byte arrived after the ROM was full.
- loaded, out, 1: contents are valid; block is in RUN.
- a, in, ADDR_W: read word address.
- ce, in, 1: chip enable.
- oe, in, 1: output enable.
- d, out, DATA_W: read data.
- d_valid, out, 1: d updated this cycle.

Behaviour:
- States: EMPTY, LOAD, RUN.
- Reset values: state=EMPTY, byte_cnt=0, waddr=0, assembly register=0, d=0, d_valid=0, dl_ready=0, dl_done=0, overrun=0, loaded=0. RAM contents are not reset.
- EMPTY to LOAD: on dl_start. Also sets dl_ready=1, clears byte_cnt, waddr and overrun.
- LOAD, byte accept:
  - A byte is accepted when dl_valid && dl_ready.
  - It is shifted into the assembly register in the position set by BIG_ENDIAN and byte_cnt.
  - byte_cnt wraps at DATA_W/8 - 1.
  - On the last byte of a word: write RAM[waddr] in the same cycle, then waddr++.
- LOAD to RUN on full: when the word at waddr = 2^ADDR_W-1 is written.
  - Clear dl_ready, pulse dl_done, set loaded.
- LOAD to RUN on dl_end:
  - If byte_cnt != 0, the partial word is written with missing bytes = 0x00.
  - Remaining RAM words keep their prior contents.
  - Then dl_done and loaded, as above.
- Simultaneous dl_valid and dl_end: the byte is included first, then the end is processed. The terminating write happens in the same cycle.
- dl_start in LOAD or RUN: restart at word 0 and go to LOAD. loaded=0, partial word discarded.
  - dl_start has priority over dl_valid and dl_end in the same cycle.
- Bytes offered while dl_ready=0 are ignored, with one exception: in RUN after a full load, dl_valid=1 sets overrun.
- Reads:
  - ce && oe sampled at posedge while in RUN.
  - d = RAM[a] after READ_LAT clocks, with d_valid high for exactly that one cycle.
  - Back-to-back reads are accepted every cycle, fully pipelined.
  - Reads in EMPTY or LOAD produce d=0 with d_valid=1 after READ_LAT, so the CPU never stalls.
  - When ce or oe is low, d holds its last value and d_valid=0.
  - A read in flight when dl_start arrives still completes with the old RAM data.
- Reset asserted mid-load: returns to EMPTY immediately, and loaded drops asynchronously.

Optional Feature:
- Macro: ROM_CHECKSUM_EN.
- When defined:
  - Adds output csum[15:0]: a mod-2^16 sum of every accepted byte.
  - Cleared on reset and dl_start.
  - Frozen once dl_done pulses.
  - Padding bytes are not counted.
- When undefined: the port and its adder are absent, and the rest of the behaviour is identical.

Test Plan:
- DATA_W=16, ADDR_W=4, BIG_ENDIAN=1, READ_LAT=1:
  - Stimulus: dl_start, then 32 bytes 0x00..0x1F.
  - Required: dl_done pulses on the byte-0x1F cycle+1 and loaded=1.
  - Required: read a=3 gives d=0x0607 with d_valid one clock later.
- Same config, BIG_ENDIAN=0:
  - Stimulus: bytes 0xAA, 0x55, then dl_end after 3 bytes with third byte 0x11.
  - Required: RAM[0]=0x55AA, RAM[1]=0x0011, dl_done pulses.
- READ_LAT=2, full load:
  - Stimulus: ce=oe=1 for 4 cycles, a=0,1,2,3.
  - Required: 4 consecutive d_valid cycles starting 2 clocks later, data in order.
- Full load, then one extra dl_valid byte:
  - Required: overrun=1 and sticky; RAM unchanged.
  - Then dl_start: overrun=0, loaded=0.
- Mid-load (10 bytes):
  - Stimulus: reset_n low.
  - Required: loaded=0, dl_ready=0, d=0 asynchronously.
  - Stimulus: read during EMPTY.
  - Required: d=0, d_valid=1.
- ROM_CHECKSUM_EN defined, 32 bytes 0x00..0x1F:
  - Required: csum=0x01F0.
  - Stimulus: dl_start.
  - Required: csum=0x0000.
